dma_arb_mux: RTL and testbench

Parametrised N-to-1 registered multiplexer with round-robin arbitration and valid/ready handshake, for merging DMA channel request/data streams onto a single bus-side port. Generalises the plain 2-to-1 select mux:
- N inputs.
- Selection owned internally by an arbiter.
- Packet-level grant locking.
- One output register stage.

---
 rtl/dma_pkg.sv | 31 +++
 rtl/dma_arb_mux_arbiter.sv | 23 ++
 rtl/dma_arb_mux.sv | 111 +++++++++++
 tb/tb_dma_arb_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA arbitration types, widths and the round-robin search helper.
package dma_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam int DMA_DATA_W = 32;
   localparam int DMA_MAX_N  = 16;

   // First set req bit after ptr, wrapping modulo n; ptr itself ranks last.
   function automatic logic [3:0] rr_next(
      input logic [3:0]  ptr,
      input logic [15:0] req,
      input int          n
   );
      logic [3:0] r;
      int         k;
      r = ptr;
      k = 0;
      for (int i = DMA_MAX_N; i >= 1; i--) begin
         if (i <= n) begin
            k = (int'(ptr) + i) % n;
            if (req[k[3:0]]) r = k[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dma_arb_mux_arbiter.sv
// Combinational round-robin arbiter: request vector + pointer -> grant.
module dma_rr_arbiter
   import dma_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_IN-1:0]  gnt,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   assign any = |req;
   assign idx = SEL_W'(rr_next(4'(ptr), 16'(req), N_IN));

   always_comb begin
      gnt = '0;
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/dma_arb_mux.sv
// N-to-1 registered DMA stream mux with packet-locked round-robin grant.
// Define DMA_ARB_MUX_PRIO_EN for fixed lowest-index priority instead.
module dma_arb_mux
   import dma_pkg::*;
#(
   parameter int SIZE  = DMA_DATA_W,
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IN-1:0]      in_valid,
   output logic [N_IN-1:0]      in_ready,
   input  logic [N_IN*SIZE-1:0] in_data,
   input  logic [N_IN-1:0]      in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SIZE-1:0]      out_data,
   output logic                 out_last,
   output logic [SEL_W-1:0]     out_sel
);

   arb_state_e       state, nxt;
   logic [SEL_W-1:0] lock_g;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gidx;
   logic [SEL_W-1:0] g;
   logic [N_IN-1:0]  gnt;
   logic             any;
   logic             stage_free;
   logic             accept;
   logic [SIZE-1:0]  bdata;
   logic             blast;

   dma_rr_arbiter #(
      .N_IN  (N_IN),
      .SEL_W (SEL_W)
   ) u_arb (
      .req (in_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx),
      .any (any)
   );

   assign stage_free = !out_valid || out_ready;
   assign g          = (state == ARB_LOCKED) ? lock_g : gidx;
   assign accept     = |(in_ready & in_valid);
   assign blast      = in_last[g];

   always_comb begin
      in_ready = '0;
      if (stage_free) begin
         if (state == ARB_LOCKED) in_ready[lock_g] = 1'b1;
         else                     in_ready = gnt;
      end
   end

   always_comb begin
      bdata = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (g == SEL_W'(i)) bdata = in_data[i*SIZE +: SIZE];
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ARB_IDLE:   if (accept && !blast) nxt = ARB_LOCKED;
         ARB_LOCKED: if (accept && blast)  nxt = ARB_IDLE;
         default:    nxt = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         lock_g <= '0;
      end else begin
         state <= nxt;
         if (accept && state == ARB_IDLE) lock_g <= g;
      end
   end

`ifdef DMA_ARB_MUX_PRIO_EN
   // Pinning the pointer to the top index makes the search start at 0.
   assign ptr = SEL_W'(N_IN-1);
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                ptr <= SEL_W'(N_IN-1);
      else if (accept && blast)  ptr <= g;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= bdata;
         out_last  <= blast;
         out_sel   <= g;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dma_arb_mux.sv
// Self-checking bench for dma_arb_mux (SIZE=32, N_IN=4).
module tb_dma_arb_mux;

   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      bit           bub;
   } beat_t;

   typedef struct {
      int           sel;
      logic [W-1:0] data;
   } xfer_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_last = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [1:0]     out_sel;

   int tests = 0;
   int fails = 0;

   beat_t q[N][$];
   xfer_t got[$];
   int    exp_q[$];

   dma_arb_mux #(.SIZE(W), .N_IN(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Upstream sources: one queue of beats per channel, bubbles drop valid.
   function automatic void drive();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && !q[i][0].bub) begin
            in_valid[i]         = 1'b1;
            in_data[i*W +: W]   = q[i][0].data;
            in_last[i]          = q[i][0].last;
         end else begin
            in_valid[i]         = 1'b0;
            in_data[i*W +: W]   = '0;
            in_last[i]          = 1'b0;
         end
      end
   endfunction

   task automatic push(input int ch, input logic [W-1:0] d,
                       input logic l, input bit b);
      beat_t e;
      e.data = d;
      e.last = l;
      e.bub  = b;
      q[ch].push_back(e);
   endtask

   always begin
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
               if (q[i][0].bub || (in_valid[i] && in_ready[i]))
                  void'(q[i].pop_front());
            end
         end
      end
      #1 drive();
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready)
         got.push_back('{int'(out_sel), out_data});
   end

   // Reference model: who owns the port, who was served last, output reg.
   int           m_lock;
   int           m_ptr;
   bit           m_ov;
   logic [W-1:0] m_data;
   logic         m_last;
   int           m_sel;

   function automatic int m_grant();
      if (m_lock >= 0) return m_lock;
`ifdef DMA_ARB_MUX_PRIO_EN
      for (int c = 0; c < N; c++)
         if (in_valid[c]) return c;
`else
      for (int k = 1; k <= N; k++)
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready();
      int gg;
      gg = m_grant();
      if (gg >= 0 && (!m_ov || out_ready)) return N'(1 << gg);
      return '0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int  gg;
      bit  acc;
      if (!rst_n) begin
         m_lock = -1;
         m_ptr  = N - 1;
         m_ov   = 1'b0;
         m_data = '0;
         m_last = 1'b0;
         m_sel  = 0;
      end else begin
         gg  = m_grant();
         acc = gg >= 0 && (!m_ov || out_ready) && in_valid[gg];
         if (acc) begin
            m_ov   = 1'b1;
            m_data = in_data[gg*W +: W];
            m_last = in_last[gg];
            m_sel  = gg;
            if (in_last[gg]) begin
               m_lock = -1;
               m_ptr  = gg;
            end else begin
               m_lock = gg;
            end
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", 32'(in_ready), 32'(m_ready()));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_last", 32'(out_last), 32'(m_last));
            chk("out_sel", 32'(out_sel), 32'(m_sel));
         end
      end
   end

   task automatic drain(input string nm);
      int n;
      bit busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
         busy = out_valid;
         for (int i = 0; i < N; i++)
            if (q[i].size() > 0) busy = 1'b1;
      end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, n);
      end
   endtask

   task automatic check_seq(input string nm, input int e[$]);
      chk({nm, "_count"}, 32'(got.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < got.size(); i++)
         chk({nm, "_sel"}, 32'(got[i].sel), 32'(e[i]));
      got.delete();
   endtask

   initial begin
      // 1: reset, then idle
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_out_data", out_data, 32'd0);
      chk("idle_out_sel", 32'(out_sel), 32'd0);

      // 2: single-beat round robin
      @(posedge clk);
      for (int i = 0; i < N; i++) push(i, 32'hA0 + 32'(i), 1'b1, 1'b0);
      push(0, 32'hA0, 1'b1, 1'b0);
      drain("rr");
      chk("rr_data2", got.size() > 2 ? got[2].data : 32'hx, 32'hA2);
`ifdef DMA_ARB_MUX_PRIO_EN
      exp_q = '{0, 0, 1, 2, 3};
`else
      exp_q = '{0, 1, 2, 3, 0};
`endif
      check_seq("rr", exp_q);

      // 3: packet lock with a bubble on the locked channel
      @(posedge clk);
      push(1, 32'hB1, 1'b0, 1'b0);
      push(1, 32'hB2, 1'b0, 1'b0);
      push(1, 32'h0,  1'b0, 1'b1);
      push(1, 32'hB3, 1'b1, 1'b0);
      push(2, 32'hC1, 1'b1, 1'b0);
      drain("lock");
      exp_q = '{1, 1, 1, 2};
      check_seq("lock", exp_q);

      // 4: backpressure
      out_ready = 1'b0;
      @(posedge clk);
      push(0, 32'hD0, 1'b1, 1'b0);
      push(0, 32'hD1, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      chk("bp_out_data", out_data, 32'hD0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      drain("bp");
      chk("bp_beat0", got.size() > 0 ? got[0].data : 32'hx, 32'hD0);
      chk("bp_beat1", got.size() > 1 ? got[1].data : 32'hx, 32'hD1);
      exp_q = '{0, 0};
      check_seq("bp", exp_q);

      // 5: asynchronous reset in the middle of a ch3 packet
      @(posedge clk);
      for (int i = 0; i < 4; i++) push(3, 32'hE0 + 32'(i), 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("arst_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < N; i++) q[i].delete();
      drive();
      got.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      for (int i = 0; i < N; i++) push(i, 32'hF0 + 32'(i), 1'b1, 1'b0);
      drain("arst");
      exp_q = '{0, 1, 2, 3};
      check_seq("arst", exp_q);

      // 6: ch0 and ch2 competing with single-beat packets
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         push(0, 32'h10 + 32'(i), 1'b1, 1'b0);
         push(2, 32'h20 + 32'(i), 1'b1, 1'b0);
      end
      drain("pair");
`ifdef DMA_ARB_MUX_PRIO_EN
      exp_q = '{0, 0, 2, 2};
`else
      exp_q = '{0, 2, 0, 2};
`endif
      check_seq("pair", exp_q);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
